// File: rtl/alu_defs.sv
// Shared definitions for the ALU issue stage: widths, ALU mode encodings and instruction layout.
package alu_defs;

   localparam int DATA_W = 16;
   localparam int NREGS  = 8;
   localparam int REG_AW = $clog2(NREGS);
   localparam int IMM_W  = 6;

   typedef enum logic [2:0] {
      ADD    = 3'd0,
      SUBST  = 3'd1,
      SHIFTR = 3'd2,
      SHIFTL = 3'd3,
      AND    = 3'd4,
      OR     = 3'd5,
      NOT    = 3'd6,
      XOR    = 3'd7
   } alu_mode_e;

   // low6 doubles as {rs2, 3'bx} for register forms and as imm6 for immediate forms
   typedef struct packed {
      logic [2:0]        mode;
      logic [REG_AW-1:0] rd;
      logic [REG_AW-1:0] rs1;
      logic              use_imm;
      logic [IMM_W-1:0]  low6;
   } instr_t;

endpackage

// File: rtl/alu_regfile.sv
// Register file: NREGS x DATA_W, two asynchronous read ports, one synchronous write port, r0 reads zero.
module alu_regfile
   import alu_defs::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic [REG_AW-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [REG_AW-1:0] raddr_a,
   output logic [DATA_W-1:0] rdata_a,
   input  logic [REG_AW-1:0] raddr_b,
   output logic [DATA_W-1:0] rdata_b
);

   logic [DATA_W-1:0] regs_q [NREGS];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      end else if (we && (waddr != '0)) begin
         regs_q[waddr] <= wdata;
      end
   end

   assign rdata_a = (raddr_a == '0) ? '0 : regs_q[raddr_a];
   assign rdata_b = (raddr_b == '0) ? '0 : regs_q[raddr_b];

endmodule

// File: rtl/alu_issue_stage.sv
// Operand-fetch/issue stage in front of the 16-bit ALU: decode, forwarding, EX register,
// writeback of the ALU result and Z/N flags.
module alu_issue_stage
   import alu_defs::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              instr_valid,
   output logic              instr_ready,
   input  logic [15:0]       instr,
   output logic [DATA_W-1:0] alu_in1,
   output logic [DATA_W-1:0] alu_in2,
   output logic [2:0]        alu_mode,
   input  logic [DATA_W-1:0] alu_result,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [DATA_W-1:0] res_data,
   output logic [REG_AW-1:0] res_rd,
   output logic              flag_z,
   output logic              flag_n
);

   instr_t            ins;
   logic [REG_AW-1:0] rs2;
   logic [DATA_W-1:0] rf_a, rf_b;
   logic [DATA_W-1:0] op_a, op_b;
   logic              accept, retire;

   logic              ex_valid_q, ex_valid_d;
   logic [DATA_W-1:0] in1_q, in1_d, in2_q, in2_d;
   logic [2:0]        mode_q, mode_d;
   logic [REG_AW-1:0] rd_q, rd_d;
   logic              flag_z_q, flag_n_q;

   assign ins = instr_t'(instr);
   assign rs2 = ins.low6[IMM_W-1 -: REG_AW];

   assign instr_ready = !ex_valid_q || res_ready;
   assign accept      = instr_valid && instr_ready;
   assign retire      = ex_valid_q && res_ready;

   alu_regfile u_regfile (
      .clk     (clk),
      .rst_n   (rst_n),
      .we      (retire),
      .waddr   (rd_q),
      .wdata   (alu_result),
      .raddr_a (ins.rs1),
      .rdata_a (rf_a),
      .raddr_b (rs2),
      .rdata_b (rf_b)
   );

   // Bypass the result retiring this cycle so a dependent instruction never sees a stale read
   always_comb begin
      op_a = rf_a;
      op_b = rf_b;
      if (retire && (rd_q != '0) && (rd_q == ins.rs1)) op_a = alu_result;
      if (retire && (rd_q != '0) && (rd_q == rs2))     op_b = alu_result;
      if (ins.use_imm) op_b = {{(DATA_W-IMM_W){1'b0}}, ins.low6};
   end

   always_comb begin
      ex_valid_d = ex_valid_q;
      in1_d      = in1_q;
      in2_d      = in2_q;
      mode_d     = mode_q;
      rd_d       = rd_q;
      if (accept) begin
         ex_valid_d = 1'b1;
         in1_d      = op_a;
         in2_d      = op_b;
         mode_d     = ins.mode;
         rd_d       = ins.rd;
      end else if (retire) begin
         ex_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_valid_q <= 1'b0;
         in1_q      <= '0;
         in2_q      <= '0;
         mode_q     <= ADD;
         rd_q       <= '0;
         flag_z_q   <= 1'b0;
         flag_n_q   <= 1'b0;
      end else begin
         ex_valid_q <= ex_valid_d;
         in1_q      <= in1_d;
         in2_q      <= in2_d;
         mode_q     <= mode_d;
         rd_q       <= rd_d;
         if (retire) begin
            flag_z_q <= (alu_result == '0);
            flag_n_q <= alu_result[DATA_W-1];
         end
      end
   end

   assign alu_in1   = in1_q;
   assign alu_in2   = in2_q;
   assign alu_mode  = mode_q;
   assign res_valid = ex_valid_q;
   assign res_data  = ex_valid_q ? alu_result : '0;
   assign res_rd    = rd_q;
   assign flag_z    = flag_z_q;
   assign flag_n    = flag_n_q;

endmodule
